// File: rtl/capture_buffer.sv
// Sample-capture buffer: stores qualified stream samples into a DEPTH x DATA_W array
// in one-shot or circular mode, with status flags and a registered read-back port.
module capture_buffer #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   input  logic              start,
   input  logic              mode,
   input  logic              stop,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              busy,
   output logic              done,
   output logic              wrapped,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W:0]   count,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);

   state_t              state;
   state_t              state_nxt;
   logic                mode_q;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                wr_en;
   logic                start_ok;
   logic                ptr_last;

   // Handshake: a sample transfers on any cycle with din_valid && enable while
   // capturing; there is no backpressure, so unqualified samples are simply dropped.
   assign wr_en    = (state == CAPTURE) && enable && din_valid;
   assign start_ok = start && (state != CAPTURE);
   assign ptr_last = (wr_ptr == LAST_PTR);

   // busy/done together encode the FSM state (neither high means IDLE).
   assign busy = (state == CAPTURE);
   assign done = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CAPTURE;
         CAPTURE: begin
            if (!mode_q && wr_en && (count == DEPTH_C - 1'b1))
               state_nxt = DONE;
            else if (mode_q && stop)
               state_nxt = DONE;
         end
         DONE:    if (start) state_nxt = CAPTURE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= IDLE;
         mode_q  <= 1'b0;
         wr_ptr  <= '0;
         count   <= '0;
         wrapped <= 1'b0;
         rd_data <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            mode_q  <= mode;
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
         end else if (wr_en) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_last ? '0 : wr_ptr + 1'b1;
            if (count != DEPTH_C) count <= count + 1'b1;
            // Only circular capture can wrap; one-shot ends on the same write.
            if (ptr_last && mode_q) wrapped <= 1'b1;
         end
         // Reads see the pre-write contents because mem updates non-blocking.
         rd_data <= ({1'b0, rd_addr} < DEPTH_C) ? mem[rd_addr] : '0;
      end
   end

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer: an 8-deep and a 5-deep instance, with expected
// status and read-back values queued by the drivers and checked by a negedge monitor.
module tb_capture_buffer;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   // 8-deep instance
   logic       enable8, start8, mode8, stop8, din_valid8;
   logic [3:0] din8, rd_data8;
   logic       busy8, done8, wrapped8;
   logic [2:0] wr_ptr8, rd_addr8;
   logic [3:0] count8;

   // 5-deep instance
   logic       enable5, start5, mode5, stop5, din_valid5;
   logic [3:0] din5, rd_data5;
   logic       busy5, done5, wrapped5;
   logic [3:0] wr_ptr5, rd_addr5;
   logic [4:0] count5;

   capture_buffer u_dut8 (
      .clk(clk), .rstn(rstn), .enable(enable8), .start(start8), .mode(mode8),
      .stop(stop8), .din(din8), .din_valid(din_valid8), .busy(busy8), .done(done8),
      .wrapped(wrapped8), .wr_ptr(wr_ptr8), .count(count8), .rd_addr(rd_addr8),
      .rd_data(rd_data8)
   );

   capture_buffer #(.DATA_W(4), .DEPTH(5), .ADDR_W(4)) u_dut5 (
      .clk(clk), .rstn(rstn), .enable(enable5), .start(start5), .mode(mode5),
      .stop(stop5), .din(din5), .din_valid(din_valid5), .busy(busy5), .done(done5),
      .wrapped(wrapped5), .wr_ptr(wr_ptr5), .count(count5), .rd_addr(rd_addr5),
      .rd_data(rd_data5)
   );

   // Scoreboard queues: status words and read data, per instance
   logic [11:0] st_q8[$], st_q5[$];
   logic [11:0] rd_q8[$], rd_q5[$];
   logic st_req8 = 1'b0, st_req5 = 1'b0;
   logic rd_req8 = 1'b0, rd_req5 = 1'b0;
   logic rd_pend8 = 1'b0, rd_pend5 = 1'b0;
   int checks = 0;
   int errors = 0;

   always @(posedge clk) begin
      rd_pend8 <= rd_req8;
      rd_pend5 <= rd_req5;
   end

   task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compares whatever the DUTs present against the queued expectations
   always @(negedge clk) begin
      if (st_req8) begin
         if (st_q8.size() == 0) check("status8_queue_empty", 12'd1, 12'd0);
         else check("status8", {2'b0, busy8, done8, wrapped8, wr_ptr8, count8}, st_q8.pop_front());
      end
      if (rd_pend8) begin
         if (rd_q8.size() == 0) check("read8_queue_empty", 12'd1, 12'd0);
         else check("read8", {8'b0, rd_data8}, rd_q8.pop_front());
      end
      if (st_req5) begin
         if (st_q5.size() == 0) check("status5_queue_empty", 12'd1, 12'd0);
         else check("status5", {busy5, done5, wrapped5, wr_ptr5, count5}, st_q5.pop_front());
      end
      if (rd_pend5) begin
         if (rd_q5.size() == 0) check("read5_queue_empty", 12'd1, 12'd0);
         else check("read5", {8'b0, rd_data5}, rd_q5.pop_front());
      end
   end

   // Advance one cycle; single-cycle pulses and check requests drop afterwards
   task automatic tick();
      @(posedge clk);
      #1;
      start8 = 1'b0; stop8 = 1'b0; start5 = 1'b0; stop5 = 1'b0;
      rd_req8 = 1'b0; rd_req5 = 1'b0; st_req8 = 1'b0; st_req5 = 1'b0;
   endtask

   task automatic exp_st8(input logic b, input logic d, input logic w, input int ptr, input int cnt);
      st_q8.push_back({2'b0, b, d, w, 3'(ptr), 4'(cnt)});
      st_req8 = 1'b1;
   endtask

   task automatic exp_st5(input logic b, input logic d, input logic w, input int ptr, input int cnt);
      st_q5.push_back({b, d, w, 4'(ptr), 5'(cnt)});
      st_req5 = 1'b1;
   endtask

   task automatic read8(input int a, input int exp);
      rd_addr8 = 3'(a);
      rd_req8  = 1'b1;
      rd_q8.push_back(12'(exp));
   endtask

   task automatic read5(input int a, input int exp);
      rd_addr5 = 4'(a);
      rd_req5  = 1'b1;
      rd_q5.push_back(12'(exp));
   endtask

   logic [3:0] exp3 [8];
   logic [3:0] exp4 [8];
   logic [3:0] exp6 [8];
   logic [3:0] exp5 [5];
   int acc;

   initial begin
      exp3 = '{4'd3, 4'd5, 4'd11, 4'd13, 4'd15, 4'd1, 4'd3, 4'd5};
      exp4 = '{4'd9, 4'd10, 4'd11, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      exp6 = '{4'd12, 4'd13, 4'd11, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      exp5 = '{4'd6, 4'd7, 4'd3, 4'd4, 4'd5};

      rstn = 1'b0;
      enable8 = 1'b1; start8 = 1'b0; mode8 = 1'b0; stop8 = 1'b0; din8 = '0;
      din_valid8 = 1'b0; rd_addr8 = '0;
      enable5 = 1'b1; start5 = 1'b0; mode5 = 1'b0; stop5 = 1'b0; din5 = '0;
      din_valid5 = 1'b0; rd_addr5 = '0;
      tick();
      tick();
      rstn = 1'b1;

      // 1: partial capture, then reset mid-capture clears everything
      start8 = 1'b1;
      tick();
      din8 = 4'd5; din_valid8 = 1'b1;
      repeat (3) tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      din_valid8 = 1'b0;
      exp_st8(0, 0, 0, 0, 0);
      exp_st5(0, 0, 0, 0, 0);
      for (int a = 0; a < 8; a++) begin
         read8(a, 0);
         tick();
      end

      // 2: one-shot fill; read the entry being written to see its old value
      mode8 = 1'b0; start8 = 1'b1;
      tick();
      exp_st8(1, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         din8 = 4'(i); din_valid8 = 1'b1;
         read8(i - 1, 0);
         tick();
         if (i < 8) exp_st8(1, 0, 0, i, i);
         else       exp_st8(0, 1, 0, 0, 8);
      end
      din8 = 4'd15;
      tick();
      din_valid8 = 1'b0;
      for (int a = 0; a < 8; a++) begin
         read8(a, a + 1);
         tick();
      end

      // 3: qualifiers; start mid-capture must be ignored
      start8 = 1'b1;
      tick();
      acc = 0;
      for (int c = 0; c < 19; c++) begin
         enable8    = !(c >= 4 && c <= 6);
         din_valid8 = (c % 2 == 0);
         din8       = 4'((c + 3) % 16);
         start8     = (c == 2);
         if (enable8 && din_valid8) acc++;
         tick();
         if (acc < 8) exp_st8(1, 0, 0, acc, acc);
         else         exp_st8(0, 1, 0, 0, 8);
      end
      enable8 = 1'b1; din_valid8 = 1'b0;
      for (int a = 0; a < 8; a++) begin
         read8(a, int'(exp3[a]));
         tick();
      end

      // 4: circular, stop together with the 11th sample
      mode8 = 1'b1; start8 = 1'b1;
      tick();
      exp_st8(1, 0, 0, 0, 0);
      for (int i = 1; i <= 11; i++) begin
         din8 = 4'(i); din_valid8 = 1'b1; stop8 = (i == 11);
         tick();
         if (i < 8)       exp_st8(1, 0, 0, i, i);
         else if (i < 11) exp_st8(1, 0, 1, i - 8, 8);
         else             exp_st8(0, 1, 1, 3, 8);
      end
      din_valid8 = 1'b0;
      for (int a = 0; a < 8; a++) begin
         read8(a, int'(exp4[a]));
         tick();
      end

      // 6: restart from DONE in one-shot; untouched entries keep old data
      mode8 = 1'b0; start8 = 1'b1;
      tick();
      exp_st8(1, 0, 0, 0, 0);
      for (int i = 1; i <= 2; i++) begin
         din8 = 4'(11 + i); din_valid8 = 1'b1;
         tick();
         exp_st8(1, 0, 0, i, i);
      end
      din_valid8 = 1'b0;
      for (int a = 0; a < 8; a++) begin
         read8(a, int'(exp6[a]));
         tick();
      end

      // 5: non-power-of-2 depth, circular, stop alone
      mode5 = 1'b1; start5 = 1'b1;
      tick();
      exp_st5(1, 0, 0, 0, 0);
      for (int i = 1; i <= 7; i++) begin
         din5 = 4'(i); din_valid5 = 1'b1;
         tick();
         if (i < 5) exp_st5(1, 0, 0, i, i);
         else       exp_st5(1, 0, 1, i - 5, 5);
      end
      din_valid5 = 1'b0; stop5 = 1'b1;
      tick();
      exp_st5(0, 1, 1, 2, 5);
      for (int a = 0; a < 5; a++) begin
         read5(a, int'(exp5[a]));
         tick();
      end
      read5(9, 0);
      tick();
      read5(15, 0);
      tick();

      tick();
      tick();
      check("leftover_status8", 12'(st_q8.size()), 12'd0);
      check("leftover_read8", 12'(rd_q8.size()), 12'd0);
      check("leftover_status5", 12'(st_q5.size()), 12'd0);
      check("leftover_read5", 12'(rd_q5.size()), 12'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/capture_buffer.md
Name: capture_buffer

Overview:
- Parametrised sample-capture buffer: records consecutive valid samples of a data stream into an internal register array of DEPTH x DATA_W.
- Next generation of the fixed 8 x 4-bit load-on-clock buffer.
- Adds one-shot and circular capture modes, a start/stop handshake, status flags and a registered read-back port.
- Sits between a sample source (counter, ADC model, bus monitor) and a debug/readout path.

Parameters:
- DATA_W, 4, sample width in bits (>=1)
- DEPTH, 8, number of entries (>=2, need not be a power of 2)
- ADDR_W, 3, pointer/address width; requires 2**ADDR_W >= DEPTH

Ports:
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  reset, synchronous, active-low
- enable  input  1  global capture qualifier; samples accepted only when high
- start  input  1  single-cycle pulse, begins capture (honoured in IDLE and DONE only)
- mode  input  1  0 = one-shot, 1 = circular; sampled on the accepted start cycle
- stop  input  1  ends circular capture; ignored in one-shot mode and outside CAPTURE
- din  input  DATA_W  sample data
- din_valid  input  1  sample strobe
- busy  output  1  high in CAPTURE
- done  output  1  high in DONE
- wrapped  output  1  circular capture has overwritten at least one entry
- wr_ptr  output  ADDR_W  next write index (= oldest entry once wrapped)
- count  output  ADDR_W+1  accepted samples, saturating at DEPTH
- rd_addr  input  ADDR_W  read-back address
- rd_data  output  DATA_W  registered read data

Behaviour:
- Reset (rstn=0 at a clk edge), taking priority over all other inputs:
  - state=IDLE; busy=0, done=0, wrapped=0, wr_ptr=0, count=0, rd_data=0.
  - All DEPTH entries cleared to 0.
  - Reset mid-capture aborts the capture with no further writes.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE --start--> CAPTURE.
  - CAPTURE --(one-shot and DEPTH-th accepted write) or (circular and stop)--> DONE.
  - DONE --start--> CAPTURE.
- Accepted start (IDLE or DONE):
  - Latch mode; clear wr_ptr, count and wrapped.
  - Entries are NOT cleared.
  - No sample is written on the start cycle itself.
- start during CAPTURE: ignored.
- Accepted write: state==CAPTURE && enable && din_valid.
  - mem[wr_ptr] <= din.
  - wr_ptr increments, wrapping from DEPTH-1 to 0 (explicit compare, not a power-of-2 overflow).
  - count increments, saturating at DEPTH.
- One-shot mode: the write that makes count=DEPTH also moves the FSM to DONE. busy falls and done rises the following cycle, with wr_ptr=0 and count=DEPTH.
- Circular mode:
  - Writes continue past DEPTH, overwriting oldest entries.
  - wrapped sets on the first write where wr_ptr wraps DEPTH-1 -> 0, and stays set until the next start or reset.
  - stop together with an accepted write: the sample is written, then the FSM goes to DONE.
  - stop without a write: go to DONE with no write.
- Read-back:
  - rd_data <= mem[rd_addr] every cycle, in every state; 1-cycle latency.
  - rd_addr >= DEPTH returns 0.
  - A read of the entry being written in the same cycle returns the old value (read-before-write).
- done remains high until start or reset.
- No writes occur in IDLE or DONE.

Test Plan:
1. Defaults; din=5, din_valid=1 for 3 cycles after start; rstn=0 for one cycle; then read addresses 0..7 -> busy=0, count=0, wr_ptr=0, all rd_data=0; no write after reset.
2. One-shot:
   - Stimulus: start, then din=1..8 with din_valid=1 every cycle.
   - Response: busy for exactly 8 cycles; done=1 the cycle after the 8th write, count=8, wrapped=0; reads of addresses 0..7 return 1..8, each one cycle after rd_addr.
3. Qualifiers in one-shot:
   - Stimulus: din_valid alternating 1/0, and enable=0 for 3 cycles mid-stream.
   - Response: only qualified samples are stored, contiguous from index 0; count steps only on accepted writes; start issued during CAPTURE has no effect.
4. Circular:
   - Stimulus: mode=1, samples 1..11, stop together with sample 11.
   - Response: done=1, wrapped=1, wr_ptr=3, count=8; mem = 9,10,11,4,5,6,7,8.
5. DEPTH=5, ADDR_W=4, circular:
   - Stimulus: 7 samples 1..7, then stop alone.
   - Response: wr_ptr=2, mem = 6,7,3,4,5; rd_addr=9 returns 0.
6. From DONE:
   - Stimulus: start with mode=0, then 2 samples.
   - Response: done clears, busy=1, count=2, wrapped=0; entries 2..DEPTH-1 keep their prior contents.
